status_flag_reg: RTL and testbench
==================================

Name: status_flag_reg

Overview:
- Parametrised processor status register (P) with an interrupt-recognition front end. Successor to the five-flag register.
- Holds all status bits in one vector, with per-bit ALU write masks, explicit set/clear strobes, a stack load path and a push image.
- Adds NMI edge latching and IRQ masking with a one-instruction delayed I-flag effect.
- Sits between the ALU/control FSM and the interrupt sequencing logic of the CPU core.

Parameters:
DATA_W, 8, width of the status vector (bit layout N V 1 B D I Z C for 8).
RESET_VAL, 8'h34, value loaded into OUT_FLAGS on reset.
CONST_MASK, 8'h30, bits with no storage; they always read CONST_VAL.
CONST_VAL, 8'h30, hard-wired values for the CONST_MASK bits.
I_BIT, 2, index of the interrupt-disable flag.
D_BIT, 3, index of the decimal flag.
B_BIT, 4, index of the break bit in the push image.

Ports:
FSM_Signal  in  1  clock; all state updates on the falling edge
reset_n  in  1  asynchronous, active-low reset
set_flag  in  1  ALU result strobe
flag_we  in  DATA_W  per-bit enable qualifying set_flag
IN_FLAGS  in  DATA_W  ALU flag results
flag_set  in  DATA_W  per-bit force-to-1 (SEC/SEI/SED)
flag_clr  in  DATA_W  per-bit force-to-0 (CLC/CLI/CLD/CLV)
load_p  in  1  load from p_bus_in (PLP/RTI)
p_bus_in  in  DATA_W  pulled status byte
push_brk  in  1  B value in the push image (1 = BRK/PHP, 0 = IRQ/NMI)
OUT_FLAGS  out  DATA_W  current status
p_push_out  out  DATA_W  stack image of the status
irq_n  in  1  level IRQ, active-low
nmi_n  in  1  edge NMI, active on the falling level change
instr_done  in  1  instruction-boundary strobe
int_ack  in  1  interrupt entry strobe from the FSM
nmi_pending  out  1  NMI recognised at the last boundary
irq_pending  out  1  IRQ recognised at the last boundary
int_req  out  1  nmi_pending OR irq_pending

Behaviour:
- Reset (reset_n low, asynchronous)
  - OUT_FLAGS = RESET_VAL with CONST_MASK bits forced to CONST_VAL.
  - i_eff = RESET_VAL[I_BIT]; nmi_prev = 1.
  - nmi_latch, nmi_pending, irq_pending all 0.
  - Reset mid-operation discards all pending events.
- Per-bit update priority each falling edge, highest first:
  1. load_p → p_bus_in[k]
  2. flag_clr[k] → 0
  3. flag_set[k] → 1
  4. set_flag & flag_we[k] → IN_FLAGS[k]
  5. otherwise hold
  - CONST_MASK bits never change.
  - int_ack forces I to 1 after this priority is applied; it overrides everything for I_BIT.
- Outputs
  - OUT_FLAGS is registered; updates are visible one edge after the strobe.
  - p_push_out is combinational: OUT_FLAGS with CONST_MASK bits = CONST_VAL, then bit B_BIT = push_brk.
- Delayed I
  - i_eff captures OUT_FLAGS[I_BIT] on each edge where instr_done = 1.
  - IRQ masking uses i_eff, so a CLI/SEI/PLP takes effect for IRQ only at the boundary after the next one.
- NMI
  - nmi_prev samples nmi_n every edge.
  - nmi_prev = 1 with nmi_n = 0 sets nmi_latch.
  - A held-low nmi_n produces only one edge.
- Boundary (instr_done = 1)
  - nmi_pending ← nmi_latch.
  - irq_pending ← !irq_n & !i_eff, using the pre-update i_eff.
  - With instr_done = 0, pending bits hold.
- Acknowledge (int_ack = 1)
  - If nmi_pending: clear nmi_pending and nmi_latch.
  - Else clear irq_pending.
  - A new NMI edge detected on the same edge as the ack wins: nmi_latch stays 1.
- instr_done and int_ack together: the ack clear takes priority for the bit being acknowledged; the other bit samples normally.

Optional Feature:
- Macro: DECIMAL_CLR_ON_INT_EN.
- Defined: int_ack also forces OUT_FLAGS[D_BIT] to 0 (65C02 behaviour), overriding all other D updates on that edge.
- Undefined: D is unaffected by int_ack (NMOS behaviour).

Test Plan:
- Reset with defaults → OUT_FLAGS = 8'h34, int_req = 0; push_brk = 0 → p_push_out = 8'h24.
- set_flag = 1, flag_we = 8'h83, IN_FLAGS = 8'hFF, with flag_clr = 8'h01 on the same edge → OUT_FLAGS = 8'hB6 (N and Z set, C cleared by priority).
- load_p = 1 with p_bus_in = 8'h00 and flag_set = 8'hFF → OUT_FLAGS = 8'h30.
- irq_n = 0, I = 1; CLI, then boundary → irq_pending stays 0; next boundary → irq_pending = 1; int_ack → irq_pending = 0, I = 1.
- nmi_n falls and is held low across 3 boundaries with acks → nmi_pending asserts once only; a second falling edge on the ack edge → nmi_pending reasserts at the next boundary.
- With DECIMAL_CLR_ON_INT_EN: D = 1, int_ack → OUT_FLAGS[3] = 0; without it → D stays 1.

Source files
------------

// File: rtl/status_flag_reg.sv
// ---------------------------------------------------------------------------
// status_flag_reg
// Processor status register (P) with interrupt-recognition front end.
//  - Single status vector with per-bit ALU write enables, set/clear strobes,
//    stack load path and a combinational push image.
//  - NMI falling-edge latch, level IRQ masked by a delayed copy of I.
//  - All state updates on the falling edge of FSM_Signal.
// Optional build macro:
//   DECIMAL_CLR_ON_INT_EN - int_ack also clears the D flag (65C02 style).
//                           Undefined: D is untouched by int_ack (NMOS).
// ---------------------------------------------------------------------------
module status_flag_reg #(
   parameter int                DATA_W     = 8,
   parameter logic [DATA_W-1:0] RESET_VAL  = 8'h34,
   parameter logic [DATA_W-1:0] CONST_MASK = 8'h30,
   parameter logic [DATA_W-1:0] CONST_VAL  = 8'h30,
   parameter int                I_BIT      = 2,
   parameter int                D_BIT      = 3,
   parameter int                B_BIT      = 4
) (
   input  logic              FSM_Signal,
   input  logic              reset_n,
   input  logic              set_flag,
   input  logic [DATA_W-1:0] flag_we,
   input  logic [DATA_W-1:0] IN_FLAGS,
   input  logic [DATA_W-1:0] flag_set,
   input  logic [DATA_W-1:0] flag_clr,
   input  logic              load_p,
   input  logic [DATA_W-1:0] p_bus_in,
   input  logic              push_brk,
   output logic [DATA_W-1:0] OUT_FLAGS,
   output logic [DATA_W-1:0] p_push_out,
   input  logic              irq_n,
   input  logic              nmi_n,
   input  logic              instr_done,
   input  logic              int_ack,
   output logic              nmi_pending,
   output logic              irq_pending,
   output logic              int_req
);

`ifdef DECIMAL_CLR_ON_INT_EN
   localparam bit CLR_D_ON_ACK = 1'b1;
`else
   localparam bit CLR_D_ON_ACK = 1'b0;
`endif

   // Reset image with the storage-less bits already pinned to their constants.
   localparam logic [DATA_W-1:0] RESET_IMG = (RESET_VAL & ~CONST_MASK) | (CONST_VAL & CONST_MASK);

   logic [DATA_W-1:0] r_flags;
   logic [DATA_W-1:0] w_flags_nxt;
   logic              r_i_eff;
   logic              r_nmi_prev;
   logic              r_nmi_latch;
   logic              r_nmi_pending;
   logic              r_irq_pending;
   logic              w_nmi_edge;
   logic              w_ack_nmi;
   logic              w_ack_irq;
   logic [DATA_W-1:0] w_push;

   // Next status vector: per-bit priority, then interrupt-entry overrides.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_flags_nxt = r_flags;
      for (int k = 0; k < DATA_W; k++) begin
         if (load_p)
            w_flags_nxt[k] = p_bus_in[k];
         else if (flag_clr[k])
            w_flags_nxt[k] = 1'b0;
         else if (flag_set[k])
            w_flags_nxt[k] = 1'b1;
         else if (set_flag && flag_we[k])
            w_flags_nxt[k] = IN_FLAGS[k];
      end
      if (int_ack)
         w_flags_nxt[I_BIT] = 1'b1;
      if (CLR_D_ON_ACK && int_ack)
         w_flags_nxt[D_BIT] = 1'b0;
      w_flags_nxt = (w_flags_nxt & ~CONST_MASK) | (CONST_VAL & CONST_MASK);
   end

   // Interrupt bookkeeping decoded from the current state.
   always_comb begin
      w_nmi_edge = r_nmi_prev & ~nmi_n;
      w_ack_nmi  = int_ack & r_nmi_pending;
      w_ack_irq  = int_ack & ~r_nmi_pending;
   end

   // Status register and delayed I copy.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(negedge FSM_Signal or negedge reset_n) begin
      if (!reset_n) begin
         r_flags <= RESET_IMG;
         r_i_eff <= RESET_VAL[I_BIT];
      end else begin
         r_flags <= w_flags_nxt;
         if (instr_done)
            r_i_eff <= r_flags[I_BIT];
      end
   end

   // NMI edge detection and latch; a fresh edge beats the ack clear.
   always_ff @(negedge FSM_Signal or negedge reset_n) begin
      if (!reset_n) begin
         r_nmi_prev  <= 1'b1;
         r_nmi_latch <= 1'b0;
      end else begin
         r_nmi_prev <= nmi_n;
         if (w_nmi_edge)
            r_nmi_latch <= 1'b1;
         else if (w_ack_nmi)
            r_nmi_latch <= 1'b0;
      end
   end

   // Pending bits: sampled at instruction boundaries, cleared by the ack.
   always_ff @(negedge FSM_Signal or negedge reset_n) begin
      if (!reset_n) begin
         r_nmi_pending <= 1'b0;
         r_irq_pending <= 1'b0;
      end else begin
         if (w_ack_nmi)
            r_nmi_pending <= 1'b0;
         else if (instr_done)
            r_nmi_pending <= r_nmi_latch;

         if (w_ack_irq)
            r_irq_pending <= 1'b0;
         else if (instr_done)
            r_irq_pending <= ~irq_n & ~r_i_eff;
      end
   end

   // Stack image: constant bits pinned, B reflects the push source.
   always_comb begin
      w_push        = (r_flags & ~CONST_MASK) | (CONST_VAL & CONST_MASK);
      w_push[B_BIT] = push_brk;
   end

   assign OUT_FLAGS   = r_flags;
   assign p_push_out  = w_push;
   assign nmi_pending = r_nmi_pending;
   assign irq_pending = r_irq_pending;
   assign int_req     = r_nmi_pending | r_irq_pending;

endmodule

// File: tb/tb_status_flag_reg.sv
// ---------------------------------------------------------------------------
// tb_status_flag_reg
// Directed, self-checking bench for status_flag_reg (default parameters).
// Inputs change 2 ns after each falling edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_status_flag_reg;

   logic       clk;
   logic       reset_n;
   logic       set_flag;
   logic [7:0] flag_we;
   logic [7:0] in_flags;
   logic [7:0] flag_set;
   logic [7:0] flag_clr;
   logic       load_p;
   logic [7:0] p_bus_in;
   logic       push_brk;
   logic [7:0] out_flags;
   logic [7:0] p_push_out;
   logic       irq_n;
   logic       nmi_n;
   logic       instr_done;
   logic       int_ack;
   logic       nmi_pending;
   logic       irq_pending;
   logic       int_req;

   int compared   = 0;
   int mismatched = 0;

   status_flag_reg dut (
      .FSM_Signal  (clk),
      .reset_n     (reset_n),
      .set_flag    (set_flag),
      .flag_we     (flag_we),
      .IN_FLAGS    (in_flags),
      .flag_set    (flag_set),
      .flag_clr    (flag_clr),
      .load_p      (load_p),
      .p_bus_in    (p_bus_in),
      .push_brk    (push_brk),
      .OUT_FLAGS   (out_flags),
      .p_push_out  (p_push_out),
      .irq_n       (irq_n),
      .nmi_n       (nmi_n),
      .instr_done  (instr_done),
      .int_ack     (int_ack),
      .nmi_pending (nmi_pending),
      .irq_pending (irq_pending),
      .int_req     (int_req)
   );

   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   // Deassert every strobe (irq_n/nmi_n are left alone).
   task automatic idle();
      set_flag   = 1'b0;
      flag_we    = 8'h00;
      in_flags   = 8'h00;
      flag_set   = 8'h00;
      flag_clr   = 8'h00;
      load_p     = 1'b0;
      p_bus_in   = 8'h00;
      instr_done = 1'b0;
      int_ack    = 1'b0;
   endtask

   // One active (falling) edge, then settle.
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      idle();
      push_brk = 1'b0;
      irq_n    = 1'b1;
      nmi_n    = 1'b1;
      @(posedge clk);
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      compared++;
      if (out_flags !== 8'h34) begin
         mismatched++;
         $display("FAIL reset_flags: OUT_FLAGS got %h want 34", out_flags);
      end
      compared++;
      if (p_push_out !== 8'h24) begin
         mismatched++;
         $display("FAIL reset_push: p_push_out got %h want 24", p_push_out);
      end
      compared++;
      if ({nmi_pending, irq_pending, int_req} !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_pending: nmi/irq/req got %b want 000", {nmi_pending, irq_pending, int_req});
      end
      // Build up a pending NMI, then reset mid-operation must discard it.
      nmi_n = 1'b0;
      tick();
      instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
      compared++;
      if (nmi_pending !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_pre_nmi: nmi_pending got %b want 1", nmi_pending);
      end
      reset_n = 1'b0;
      #1;
      compared++;
      if ({nmi_pending, int_req} !== 2'b00) begin
         mismatched++;
         $display("FAIL reset_async_clear: nmi/req got %b want 00", {nmi_pending, int_req});
      end
      reset_n = 1'b1;
      nmi_n   = 1'b1;
      // The latch was cleared too: a boundary must not bring NMI back.
      instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
      compared++;
      if (nmi_pending !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_latch_clear: nmi_pending got %b want 0", nmi_pending);
      end
   endtask

   task automatic test_priority();
      do_reset();
      // ALU write N,Z,C with C cleared on the same edge.
      set_flag = 1'b1;
      flag_we  = 8'h83;
      in_flags = 8'hFF;
      flag_clr = 8'h01;
      tick();
      idle();
      compared++;
      if (out_flags !== 8'hB6) begin
         mismatched++;
         $display("FAIL alu_mask_clr: OUT_FLAGS got %h want B6", out_flags);
      end
      // load_p beats flag_set; constant bits stay 1.
      load_p   = 1'b1;
      p_bus_in = 8'h00;
      flag_set = 8'hFF;
      tick();
      idle();
      compared++;
      if (out_flags !== 8'h30) begin
         mismatched++;
         $display("FAIL load_over_set: OUT_FLAGS got %h want 30", out_flags);
      end
      // flag_set beats the ALU write.
      set_flag = 1'b1;
      flag_we  = 8'hFF;
      in_flags = 8'h00;
      flag_set = 8'h01;
      tick();
      idle();
      compared++;
      if (out_flags !== 8'h31) begin
         mismatched++;
         $display("FAIL set_over_alu: OUT_FLAGS got %h want 31", out_flags);
      end
      // Stack load of all ones, push image with B forced low.
      load_p   = 1'b1;
      p_bus_in = 8'hFF;
      tick();
      idle();
      compared++;
      if (out_flags !== 8'hFF) begin
         mismatched++;
         $display("FAIL load_ff: OUT_FLAGS got %h want FF", out_flags);
      end
      compared++;
      if (p_push_out !== 8'hEF) begin
         mismatched++;
         $display("FAIL push_irq: p_push_out got %h want EF", p_push_out);
      end
      // Clear everything: storage-less bits cannot be cleared; BRK push sets B.
      flag_clr = 8'hFF;
      push_brk = 1'b1;
      tick();
      idle();
      compared++;
      if (out_flags !== 8'h30) begin
         mismatched++;
         $display("FAIL clr_const: OUT_FLAGS got %h want 30", out_flags);
      end
      compared++;
      if (p_push_out !== 8'h30) begin
         mismatched++;
         $display("FAIL push_brk: p_push_out got %h want 30", p_push_out);
      end
   endtask

   task automatic test_irq_delay();
      do_reset();
      irq_n    = 1'b0;
      flag_clr = 8'h04;                      // CLI
      tick();
      idle();
      compared++;
      if (out_flags[2] !== 1'b0) begin
         mismatched++;
         $display("FAIL cli: I got %b want 0", out_flags[2]);
      end
      instr_done = 1'b1;                     // first boundary: old I still masks
      tick();
      compared++;
      if (irq_pending !== 1'b0) begin
         mismatched++;
         $display("FAIL irq_first_boundary: irq_pending got %b want 0", irq_pending);
      end
      tick();                                // second boundary: recognised
      instr_done = 1'b0;
      compared++;
      if ({irq_pending, int_req} !== 2'b11) begin
         mismatched++;
         $display("FAIL irq_second_boundary: irq/req got %b want 11", {irq_pending, int_req});
      end
      irq_n = 1'b1;
      tick();                                // no boundary: holds even with irq_n high
      compared++;
      if (irq_pending !== 1'b1) begin
         mismatched++;
         $display("FAIL irq_hold: irq_pending got %b want 1", irq_pending);
      end
      int_ack = 1'b1;
      tick();
      idle();
      compared++;
      if ({irq_pending, int_req, out_flags[2]} !== 3'b001) begin
         mismatched++;
         $display("FAIL irq_ack: irq/req/I got %b want 001", {irq_pending, int_req, out_flags[2]});
      end
   endtask

   task automatic test_nmi();
      int asserts;
      do_reset();
      asserts = 0;
      nmi_n = 1'b0;                          // falls and stays low
      tick();
      compared++;
      if (nmi_pending !== 1'b0) begin
         mismatched++;
         $display("FAIL nmi_before_boundary: nmi_pending got %b want 0", nmi_pending);
      end
      for (int b = 0; b < 3; b++) begin
         instr_done = 1'b1;
         tick();
         instr_done = 1'b0;
         if (nmi_pending === 1'b1) asserts++;
         int_ack = 1'b1;
         tick();
         int_ack = 1'b0;
      end
      compared++;
      if (asserts !== 1) begin
         mismatched++;
         $display("FAIL nmi_held_low: boundaries asserting got %0d want 1", asserts);
      end
      compared++;
      if ({nmi_pending, int_req} !== 2'b00) begin
         mismatched++;
         $display("FAIL nmi_after_acks: nmi/req got %b want 00", {nmi_pending, int_req});
      end
      // Second edge arriving on the ack edge survives the ack.
      nmi_n = 1'b1;
      tick();
      nmi_n = 1'b0;
      tick();
      instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
      nmi_n = 1'b1;
      tick();
      nmi_n   = 1'b0;
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      compared++;
      if (nmi_pending !== 1'b0) begin
         mismatched++;
         $display("FAIL nmi_ack_edge: nmi_pending got %b want 0", nmi_pending);
      end
      instr_done = 1'b1;
      tick();
      instr_done = 1'b0;
      compared++;
      if (nmi_pending !== 1'b1) begin
         mismatched++;
         $display("FAIL nmi_reassert: nmi_pending got %b want 1", nmi_pending);
      end
      // Ack together with a boundary: ack wins, latch also cleared.
      instr_done = 1'b1;
      int_ack    = 1'b1;
      tick();
      int_ack = 1'b0;
      compared++;
      if (nmi_pending !== 1'b0) begin
         mismatched++;
         $display("FAIL nmi_ack_and_boundary: nmi_pending got %b want 0", nmi_pending);
      end
      tick();
      instr_done = 1'b0;
      compared++;
      if (nmi_pending !== 1'b0) begin
         mismatched++;
         $display("FAIL nmi_latch_cleared: nmi_pending got %b want 0", nmi_pending);
      end
   endtask

   task automatic test_decimal_on_ack();
      logic [7:0] exp_flags;
`ifdef DECIMAL_CLR_ON_INT_EN
      exp_flags = 8'h34;
`else
      exp_flags = 8'h3C;
`endif
      do_reset();
      flag_set = 8'h08;                      // SED
      tick();
      idle();
      compared++;
      if (out_flags !== 8'h3C) begin
         mismatched++;
         $display("FAIL sed: OUT_FLAGS got %h want 3C", out_flags);
      end
      int_ack = 1'b1;
      tick();
      idle();
      compared++;
      if (out_flags !== exp_flags) begin
         mismatched++;
         $display("FAIL decimal_on_ack: OUT_FLAGS got %h want %h", out_flags, exp_flags);
      end
   endtask

   // Watchdog: the sequence is short; anything longer is a hang.
   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      idle();
      push_brk = 1'b0;
      irq_n    = 1'b1;
      nmi_n    = 1'b1;
      #3;
      test_reset();
      test_priority();
      test_irq_delay();
      test_nmi();
      test_decimal_on_ack();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
